// File: rtl/cla_pkg.sv
// Shared constants and types for the two-level carry-lookahead adder.
// Group size, group count helper and the per-group {G,P} pair.
package cla_pkg;

  localparam int GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_adder_block4.sv
// 4-bit lookahead group: flat sum-of-products carries,
// sum slice and group generate/propagate.
module cla_block4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output gp_t        gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    s = p ^ c;
    gp.g = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp.p = &p;
  end

endmodule

// File: rtl/cla_adder.sv
// Registered carry-lookahead adder, 1-cycle latency, valid flag.
// Define CLA_OVF_EN to add the registered signed-overflow port ovf.
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int NG = num_groups(WIDTH);

  gp_t [NG-1:0]     gp;
  logic [NG:0]      cg;
  logic [WIDTH-1:0] s_c;

  for (genvar k = 0; k < NG; k++) begin : g_blk
    cla_block4 u_blk (
      .a  (a[k*GROUP_W +: GROUP_W]),
      .b  (b[k*GROUP_W +: GROUP_W]),
      .cin(cg[k]),
      .s  (s_c[k*GROUP_W +: GROUP_W]),
      .gp (gp[k])
    );
  end

  // Each group carry is an independent product-sum of G/P/cin.
  always_comb begin
    logic acc;
    logic term;
    acc  = 1'b0;
    term = 1'b0;
    cg   = '0;
    cg[0] = cin;
    for (int k = 1; k <= NG; k++) begin
      acc = cin;
      for (int j = 0; j < k; j++)
        acc = acc & gp[j].p;
      for (int j = 0; j < k; j++) begin
        term = gp[j].g;
        for (int m = j + 1; m < k; m++)
          term = term & gp[m].p;
        acc = acc | term;
      end
      cg[k] = acc;
    end
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

`ifdef CLA_OVF_EN
  logic c_msb;
  logic ovf_d, ovf_q;

  // Carry into the MSB recovered from its sum and propagate bits.
  always_comb begin
    c_msb = s_c[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
    ovf_d = ovf_q;
    if (in_valid)
      ovf_d = cg[NG] ^ c_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s_c;
      cout_d = cg[NG];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cla_adder.sv
// Directed bench for cla_adder at WIDTH=4 and WIDTH=16.
// Define CLA_OVF_EN to also check the overflow flag.
module tb_cla_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        v4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        c4 = 1'b0;
  logic [3:0]  s4;
  logic        co4, ov4;

  logic        v16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        c16 = 1'b0;
  logic [15:0] s16;
  logic        co16, ov16;

`ifdef CLA_OVF_EN
  logic ovf4, ovf16;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4),
    .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4),
`ifdef CLA_OVF_EN
    .ovf(ovf4),
`endif
    .out_valid(ov4)
  );

  cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16),
    .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16),
`ifdef CLA_OVF_EN
    .ovf(ovf16),
`endif
    .out_valid(ov16)
  );

  task automatic op4(input logic [3:0] a, input logic [3:0] b,
                     input logic c, input logic v);
    @(negedge clk);
    a4 = a; b4 = b; c4 = c; v4 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    @(negedge clk);
    a16 = a; b16 = b; c16 = c; v16 = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op4(4'h5, 4'h3, 1'b0, 1'b1);
    n_cmp++;
    if ({co4, s4, ov4} !== {1'b0, 4'h8, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset got %b/%h/%b want 0/8/1", co4, s4, ov4);
    end
    @(negedge clk);
    a4 = 4'hE; b4 = 4'hC; c4 = 1'b0; v4 = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({co4, s4, ov4} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_async got %b/%h/%b want 0/0/0", co4, s4, ov4);
    end
    n_cmp++;
    if (ov16 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async16 got ov=%b want 0", ov16);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({co4, s4, ov4} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_held got %b/%h/%b want 0/0/0", co4, s4, ov4);
    end
    @(negedge clk);
    rst = 1'b0; v4 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({co4, s4, ov4} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_release got %b/%h/%b want 0/0/0", co4, s4, ov4);
    end
    op4(4'h1, 4'h2, 1'b0, 1'b1);
    n_cmp++;
    if ({co4, s4, ov4} !== {1'b0, 4'h3, 1'b1}) begin
      n_err++;
      $display("FAIL first_valid got %b/%h/%b want 0/3/1", co4, s4, ov4);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ta [8] = '{4'h0, 4'h1, 4'h5, 4'h4, 4'hE, 4'hF, 4'hF, 4'hF};
    logic [3:0] tb [8] = '{4'h0, 4'h2, 4'h3, 4'h7, 4'hC, 4'hF, 4'h0, 4'hF};
    logic       tc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] es [8] = '{4'h0, 4'h3, 4'h8, 4'hB, 4'hA, 4'hE, 4'h0, 4'hF};
    logic       ec [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      op4(ta[i], tb[i], tc[i], 1'b1);
      n_cmp++;
      if ({co4, s4, ov4} !== {ec[i], es[i], 1'b1}) begin
        n_err++;
        $display("FAIL directed[%0d] got %b/%h/%b want %b/%h/1",
                 i, co4, s4, ov4, ec[i], es[i]);
      end
    end
  endtask

  task automatic test_hold();
    op4(4'h1, 4'h2, 1'b0, 1'b1);
    op4(4'hA, 4'hA, 1'b0, 1'b0);
    n_cmp++;
    if ({co4, s4, ov4} !== {1'b0, 4'h3, 1'b0}) begin
      n_err++;
      $display("FAIL hold got %b/%h/%b want 0/3/0", co4, s4, ov4);
    end
    op4(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
    n_cmp++;
    if ({co4, s4, ov4} !== {1'b0, 4'h3, 1'b0}) begin
      n_err++;
      $display("FAIL hold_x got %b/%h/%b want 0/3/0", co4, s4, ov4);
    end
  endtask

  task automatic test_exhaustive4();
    logic [4:0] e;
    for (int i = 0; i < 512; i++) begin
      op4(i[7:4], i[3:0], i[8], 1'b1);
      e = {1'b0, i[7:4]} + {1'b0, i[3:0]} + {4'b0, i[8]};
      n_cmp++;
      if ({co4, s4, ov4} !== {e, 1'b1}) begin
        n_err++;
        $display("FAIL exh a=%h b=%h c=%b got %b/%h want %b/%h",
                 i[7:4], i[3:0], i[8], co4, s4, e[4], e[3:0]);
      end
`ifdef CLA_OVF_EN
      n_cmp++;
      if (ovf4 !== ((i[7] == i[3]) && (e[3] != i[7]))) begin
        n_err++;
        $display("FAIL exh_ovf a=%h b=%h c=%b got %b",
                 i[7:4], i[3:0], i[8], ovf4);
      end
`endif
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] e;
    op16(16'hFFFF, 16'h0001, 1'b0);
    n_cmp++;
    if ({co16, s16, ov16} !== {1'b1, 16'h0000, 1'b1}) begin
      n_err++;
      $display("FAIL w16_wrap got %b/%h/%b want 1/0000/1", co16, s16, ov16);
    end
    op16(16'hFFFF, 16'h0000, 1'b1);
    n_cmp++;
    if ({co16, s16} !== {1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL w16_prop got %b/%h want 1/0000", co16, s16);
    end
    op16(16'h0FFF, 16'h0000, 1'b1);
    n_cmp++;
    if ({co16, s16} !== {1'b0, 16'h1000}) begin
      n_err++;
      $display("FAIL w16_grp got %b/%h want 0/1000", co16, s16);
    end
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      op16(ra, rb, rc);
      e = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      n_cmp++;
      if ({co16, s16} !== e) begin
        n_err++;
        $display("FAIL w16_rand a=%h b=%h c=%b got %b/%h want %b/%h",
                 ra, rb, rc, co16, s16, e[16], e[15:0]);
      end
    end
    @(negedge clk);
    v16 = 1'b0;
  endtask

`ifdef CLA_OVF_EN
  task automatic test_ovf();
    op4(4'h7, 4'h1, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf4, co4, s4} !== {1'b1, 1'b0, 4'h8}) begin
      n_err++;
      $display("FAIL ovf_pos got %b/%b/%h want 1/0/8", ovf4, co4, s4);
    end
    op4(4'h8, 4'h8, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf4, co4, s4} !== {1'b1, 1'b1, 4'h0}) begin
      n_err++;
      $display("FAIL ovf_neg got %b/%b/%h want 1/1/0", ovf4, co4, s4);
    end
    op4(4'h3, 4'h2, 1'b0, 1'b1);
    n_cmp++;
    if (ovf4 !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_none got %b want 0", ovf4);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_exhaustive4();
    test_width16();
`ifdef CLA_OVF_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
